// File: rtl/adder_share_pkg.sv
// rtl/adder_share_pkg.sv - shared types and constants for the shared-adder controller
package adder_share_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic cout;
    logic pos_ovf;
    logic neg_ovf;
  } adder_flags_t;

endpackage

// File: rtl/adder_share_ctrl_core.sv
// rtl/adder_share_ctrl_core.sv - combinational WIDTH-bit adder with carry-out and signed overflow flags
module adder_core
  import adder_share_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output adder_flags_t     flags
);

  logic [WIDTH:0] full;

  // One extra bit on the left catches the carry out of the top bit
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  end

  assign sum = full[WIDTH-1:0];

  // Signed overflow only possible when both operands share a sign and the result flips it
  always_comb begin
    flags         = '0;
    flags.cout    = full[WIDTH];
    flags.pos_ovf = ~a[WIDTH-1] & ~b[WIDTH-1] &  full[WIDTH-1];
    flags.neg_ovf =  a[WIDTH-1] &  b[WIDTH-1] & ~full[WIDTH-1];
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// rtl/adder_share_ctrl.sv - arbitrates NREQ requesters onto one multicycle adder; ADDER_SHARE_RR_EN selects round-robin
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int SETTLE = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*WIDTH-1:0]      req_a,
  input  logic [NREQ*WIDTH-1:0]      req_b,
  input  logic [NREQ-1:0]            req_cin,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NREQ)-1:0]    rsp_id,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_cout,
  output logic                       rsp_pos_ovf,
  output logic                       rsp_neg_ovf,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);
  // Counter only ever holds SETTLE-1 down to 0
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic             any_valid;
  logic [IDW-1:0]   grant;
  logic             accept;
  logic             calc_done;
  logic             rsp_fire;

  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_cin;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [IDW-1:0]   op_id;

  logic [WIDTH-1:0] core_sum;
  adder_flags_t     core_flags;

`ifdef ADDER_SHARE_RR_EN
  logic [IDW-1:0]   last_grant;

  // Round-robin: first valid requester after last_grant, wrapping past NREQ-1 to 0
  always_comb begin
    int             idx;
    logic [IDW-1:0] cand;
    any_valid = 1'b0;
    grant     = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end
      cand = IDW'(idx);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        grant     = cand;
      end
    end
  end

  // Pointer moves only when a request is actually taken
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`else
  // Fixed priority: lowest index wins, so scan downward and let the last hit stick
  always_comb begin
    any_valid = |req_valid;
    grant     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant = IDW'(i);
      end
    end
  end
`endif

  assign accept    = (state == ST_IDLE) && any_valid;
  assign calc_done = (state == ST_CALC) && (cnt == '0);
  assign rsp_fire  = (state == ST_RESP) && rsp_valid && rsp_ready;
  assign busy      = (state != ST_IDLE);

  // Ready is offered only from IDLE, and only to the winner
  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Pick the granted requester's operands out of the packed buses
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_a   = req_a[i*WIDTH +: WIDTH];
        sel_b   = req_b[i*WIDTH +: WIDTH];
        sel_cin = req_cin[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: IDLE -> CALC on accept, CALC -> RESP when settled, RESP -> IDLE on handshake
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (any_valid) begin
          state_nxt = ST_CALC;
        end
      end
      ST_CALC: begin
        if (cnt == '0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch and settle counter; operands stay frozen for the whole CALC window
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_cin <= 1'b0;
      op_id  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      op_a   <= sel_a;
      op_b   <= sel_b;
      op_cin <= sel_cin;
      op_id  <= grant;
      cnt    <= CNT_LOAD;
    end else if ((state == ST_CALC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  adder_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a     (op_a),
    .b     (op_b),
    .cin   (op_cin),
    .sum   (core_sum),
    .flags (core_flags)
  );

  // Response register: capture once the carry chain has settled, hold until consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_sum     <= '0;
      rsp_cout    <= 1'b0;
      rsp_pos_ovf <= 1'b0;
      rsp_neg_ovf <= 1'b0;
    end else if (calc_done) begin
      rsp_valid   <= 1'b1;
      rsp_id      <= op_id;
      rsp_sum     <= core_sum;
      rsp_cout    <= core_flags.cout;
      rsp_pos_ovf <= core_flags.pos_ovf;
      rsp_neg_ovf <= core_flags.neg_ovf;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb/tb_adder_share_ctrl.sv - self-checking bench for adder_share_ctrl (either arbitration mode)
module tb_adder_share_ctrl;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 32;
  localparam int SETTLE = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 1;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [1:0]            rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;
  logic                  rsp_pos_ovf;
  logic                  rsp_neg_ovf;
  logic                  busy;

  logic [WIDTH-1:0] pa [NREQ];
  logic [WIDTH-1:0] pb [NREQ];
  logic             pcin [NREQ];

  int n_tests;
  int n_fail;
  int m_last;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
    assign req_a[gi*WIDTH +: WIDTH] = pa[gi];
    assign req_b[gi*WIDTH +: WIDTH] = pb[gi];
    assign req_cin[gi]              = pcin[gi];
  end

  adder_share_ctrl #(
    .NREQ   (NREQ),
    .WIDTH  (WIDTH),
    .SETTLE (SETTLE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_cin     (req_cin),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_sum     (rsp_sum),
    .rsp_cout    (rsp_cout),
    .rsp_pos_ovf (rsp_pos_ovf),
    .rsp_neg_ovf (rsp_neg_ovf),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference arbitration straight from the rules: scan order depends on mode
  function automatic int model_grant(input logic [NREQ-1:0] v, input int last);
`ifdef ADDER_SHARE_RR_EN
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Reference arithmetic: unsigned sum for value/carry, signed sum for range overflow
  task automatic model_add(input logic [31:0] a, input logic [31:0] b, input logic c,
                           output logic [31:0] s, output logic co, output logic po, output logic no);
    longint ua;
    longint sa;
    ua = longint'(a) + longint'(b) + longint'(c);
    sa = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
    s  = ua[31:0];
    co = ua[32];
    po = (sa > SMAX);
    no = (sa < SMIN);
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // One full transaction from an idle cycle; req_valid and operands already driven
  task automatic run_op(input int stall, input logic [NREQ-1:0] raise,
                        output int g, output int oid, output logic [31:0] osum,
                        output logic ocout, output logic opos, output logic oneg);
    logic [31:0] es;
    logic        ec, ep, en;
    #1;
    g = model_grant(req_valid, m_last);
    oid = -1; osum = '0; ocout = 1'b0; opos = 1'b0; oneg = 1'b0;
    if (g < 0) begin
      chk("no_request_to_run", 64'(req_ready), 64'hdead);
      return;
    end
    chk("ready_grant", 64'(req_ready), 64'(1 << g));
    chk("busy_idle", 64'(busy), 64'd0);
    model_add(pa[g], pb[g], pcin[g], es, ec, ep, en);
    m_last = g;
    tick();
    req_valid[g] = 1'b0;
    #1;
    for (int c = 1; c <= SETTLE; c++) begin
      chk("calc_busy", 64'(busy), 64'd1);
      chk("calc_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("calc_req_ready", 64'(req_ready), 64'd0);
      tick();
      #1;
    end
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_id", 64'(rsp_id), 64'(g));
    chk("rsp_sum", 64'(rsp_sum), 64'(es));
    chk("rsp_cout", 64'(rsp_cout), 64'(ec));
    chk("rsp_pos_ovf", 64'(rsp_pos_ovf), 64'(ep));
    chk("rsp_neg_ovf", 64'(rsp_neg_ovf), 64'(en));
    oid = int'(rsp_id); osum = rsp_sum; ocout = rsp_cout; opos = rsp_pos_ovf; oneg = rsp_neg_ovf;
    req_valid = req_valid | raise;
    for (int s = 0; s < stall; s++) begin
      rsp_ready = 1'b0;
      tick();
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_sum", 64'(rsp_sum), 64'(es));
      chk("hold_id", 64'(rsp_id), 64'(g));
      chk("hold_flags", 64'({rsp_cout, rsp_pos_ovf, rsp_neg_ovf}), 64'({ec, ep, en}));
      chk("hold_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    #1;
    chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_busy", 64'(busy), 64'd0);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        pos;
    logic        neg;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int          g;
    int          oid;
    logic [31:0] osum;
    logic        ocout, opos, oneg;
    int          rr_exp [5];
    int          newv;

    n_tests = 0;
    n_fail  = 0;
    m_last  = NREQ - 1;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0009, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    tbl[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    tbl[5] = '{32'h1234_5678, 32'h0EDC_BA98, 1'b0, 32'h2111_1110, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1};

    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pa[i] = '0; pb[i] = '0; pcin[i] = 1'b0;
    end
    tick();
    tick();
    #1;
    chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_pos_ovf, rsp_neg_ovf, busy}), 64'd0);
    chk("reset_sum", 64'(rsp_sum), 64'd0);
    rst = 1'b0;
    tick();
    #1;

    // Table vectors through requester 0
    for (int t = 0; t < 7; t++) begin
      pa[0] = tbl[t].a; pb[0] = tbl[t].b; pcin[0] = tbl[t].cin;
      req_valid = 4'b0001;
      run_op(0, '0, g, oid, osum, ocout, opos, oneg);
      chk("tbl_sum", 64'(osum), 64'(tbl[t].sum));
      chk("tbl_flags", 64'({ocout, opos, oneg}), 64'({tbl[t].cout, tbl[t].pos, tbl[t].neg}));
      chk("tbl_id", 64'(oid), 64'd0);
    end

    // Back-pressure: req2 arrives during a stalled response, taken right after the handshake
    pa[0] = 32'h1111_1111; pb[0] = 32'h2222_2222; pcin[0] = 1'b0;
    pa[2] = 32'h0F0F_0F0F; pb[2] = 32'h0101_0101; pcin[2] = 1'b1;
    req_valid = 4'b0001;
    run_op(10, 4'b0100, g, oid, osum, ocout, opos, oneg);
    run_op(0, '0, g, oid, osum, ocout, opos, oneg);
    chk("bp_next_id", 64'(oid), 64'd2);
    chk("bp_next_sum", 64'(osum), 64'h1010_1011);

    // Reset in the middle of CALC drops the operation
    pa[1] = 32'h0000_0010; pb[1] = 32'h0000_0020; pcin[1] = 1'b0;
    req_valid = 4'b0010;
    #1;
    chk("rst_test_grant", 64'(req_ready), 64'b0010);
    tick();
    req_valid = '0;
    #1;
    chk("rst_test_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", 64'({req_ready, rsp_valid, rsp_id, rsp_cout, rsp_pos_ovf, rsp_neg_ovf, busy}), 64'd0);
    chk("midreset_sum", 64'(rsp_sum), 64'd0);
    tick();
    rst = 1'b0;
    m_last = NREQ - 1;
    tick();
    chk("midreset_no_rsp", 64'({rsp_valid, busy}), 64'd0);

    for (int i = 0; i < NREQ; i++) begin
      pa[i] = rand_op(); pb[i] = rand_op(); pcin[i] = 1'($urandom_range(0, 1));
    end
    req_valid = 4'b1111;
    run_op(0, '0, g, oid, osum, ocout, opos, oneg);
    chk("fresh_first_id", 64'(oid), 64'd0);

`ifdef ADDER_SHARE_RR_EN
    rr_exp = '{0, 1, 2, 3, 0};
    for (int k = 1; k < 5; k++) begin
      pa[g] = rand_op(); pb[g] = rand_op(); req_valid[g] = 1'b1;
      run_op(0, '0, g, oid, osum, ocout, opos, oneg);
      chk("rr_order_id", 64'(oid), 64'(rr_exp[k]));
    end
`else
    rr_exp = '{1, 1, 1, 1, 1};
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      run_op(0, '0, g, oid, osum, ocout, opos, oneg);
      chk("fixed_pri_id", 64'(oid), 64'(rr_exp[k]));
      pa[1] = rand_op(); pb[1] = rand_op(); req_valid[1] = 1'b1;
    end
`endif
    req_valid = '0;

    // Randomized traffic against the reference model
    for (int n = 0; n < 40; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          pa[i] = rand_op(); pb[i] = rand_op(); pcin[i] = 1'($urandom_range(0, 1));
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        newv = $urandom_range(0, NREQ - 1);
        pa[newv] = rand_op(); pb[newv] = rand_op(); pcin[newv] = 1'($urandom_range(0, 1));
        req_valid[newv] = 1'b1;
      end
      run_op($urandom_range(0, 3), '0, g, oid, osum, ocout, opos, oneg);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Sequencing controller that shares one 32-bit ripple-carry adder datapath among `NREQ` requesters. It arbitrates among requests and captures the granted operands. It holds them stable for a fixed multicycle settle window, then registers the sum, carry-out and signed-overflow flags into a single response channel. It sits between the ALU-side request ports and the adder core, so that the adder's long carry chain is never required to close timing in one cycle.

## Interface
- `NREQ`, 4: number of requesters, 2..8
- `WIDTH`, 32: operand width
- `SETTLE`, 2: cycles the adder inputs are held before result capture, ≥1
- `clk` in 1: sole clock, rising edge
- `rst` in 1: reset, asynchronous and active-high
- `req_valid` in NREQ: per-requester request valid
- `req_ready` out NREQ: per-requester accept, at most one bit high
- `req_a` in NREQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH]
- `req_b` in NREQ*WIDTH: operand B, same packing
- `req_cin` in NREQ: carry-in per requester
- `rsp_valid` out 1: response valid
- `rsp_ready` in 1: response consumer ready
- `rsp_id` out $clog2(NREQ): index of the requester that owns the response
- `rsp_sum` out WIDTH: A+B+Cin modulo 2^WIDTH
- `rsp_cout` out 1: carry out of bit WIDTH-1
- `rsp_pos_ovf` out 1: signed positive overflow
- `rsp_neg_ovf` out 1: signed negative overflow
- `busy` out 1: high in CALC or RESP

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - If any `req_valid` is high, the arbiter selects grant g and drives `req_ready[g]` high combinationally in the same cycle.
  - On that edge, the block latches `req_a[g]`, `req_b[g]`, `req_cin[g]` and g, loads settle counter = SETTLE-1, and moves to CALC.
  - `req_ready` is all-zero in every other state.
- **CALC**
  - Latched operands drive the adder core.
  - The counter decrements each cycle.
  - On the cycle the counter reads 0, the block registers the adder outputs into `rsp_*`, sets `rsp_valid`, and moves to RESP.
- **RESP**
  - `rsp_*` is held stable until `rsp_valid && rsp_ready`.
  - On that edge, the block clears `rsp_valid` and returns to IDLE.
  - The block does not accept a new request in the same cycle.
- **Overflow**
  - `pos_ovf` = (a[W-1]==0 && b[W-1]==0 && sum[W-1]==1).
  - `neg_ovf` = (a[W-1]==1 && b[W-1]==1 && sum[W-1]==0).
  - Both flags are 0 when operand signs differ. They are independent of `cout`.
- **Arbitration pointer**
  - `last_grant` updates only on an accepted request.
  - Reset value of `last_grant` is NREQ-1, so requester 0 wins first.
- **Protocol**
  - A requester holds `req_valid` and its operands until it sees `req_ready`.
  - The block does not check this rule.

## Timing
- **Reset values**
  - All outputs are 0, state is IDLE and the counter is 0.
  - Reset asserted mid-operation discards the in-flight operation with no response.
- **Latency**
  - Accept in cycle 0, CALC in cycles 1..SETTLE, `rsp_valid` high from cycle SETTLE+1.
  - With `rsp_ready` held high, the next accept is possible in cycle SETTLE+2.
  - Peak throughput is one op per SETTLE+2 cycles.
- **Simultaneous requests**
  - Exactly one grant per accept. All other requesters see `req_ready`=0 and keep waiting.
- **Back-pressure**
  - If `rsp_ready` is low, the block stays in RESP indefinitely.
  - New requests are not accepted while in RESP.
- **Boundary cases**
  - SETTLE=1 gives one CALC cycle.
  - `rsp_sum` wraps modulo 2^WIDTH; carry is reported only through `rsp_cout`.

## Configuration
- **Macro:** `ADDER_SHARE_RR_EN`.
- **Defined:** round-robin arbitration. The search starts at `last_grant`+1 and wraps past NREQ-1 to 0.
- **Undefined:** fixed priority; the lowest-index valid requester always wins and `last_grant` is unused.
  - Reset and handshake behaviour are identical in both modes.

## Structure
- **Package `adder_share_pkg`:**
  - state enum (IDLE/CALC/RESP)
  - default WIDTH constant
  - `adder_flags_t` struct: cout, pos_ovf, neg_ovf
- **Sub-module `adder_core`:**
  - combinational WIDTH-bit add with cin
  - outputs sum, cout and both overflow flags
  - instantiated once by the controller, which owns all registers

## Test plan
- **Reset:** assert `rst` mid-CALC → all outputs 0 immediately, and the next request is accepted as if fresh with requester 0 first.
- **Single op, SETTLE=2:** req0 sends a=0x0000_0005, b=0x0000_0003, cin=1 → `rsp_valid` in cycle 3 with sum=0x9, cout=0, id=0, both ovf 0.
- **Overflow:**
  - 0x7FFF_FFFF+0x1 → sum=0x8000_0000, pos_ovf=1.
  - 0x8000_0000+0x8000_0000 → sum=0, cout=1, neg_ovf=1.
  - 0xFFFF_FFFF+0x1 → sum=0, cout=1, no ovf.
- **Round-robin (`ADDER_SHARE_RR_EN`):** all four requesters held valid → grant order 0,1,2,3,0, and `rsp_id` matches each.
- **Fixed priority (macro undefined):** req1 and req3 held valid → req1 is granted every time and req3 is never served while req1 stays valid.
- **Back-pressure:** hold `rsp_ready` low for 10 cycles in RESP with req2 valid → `rsp_*` stable, `req_ready` stays 0, and req2 is accepted in the cycle after the response handshake.
